// File: rtl/sum_pkg.sv
// Shared definitions for the sequential mantissa adder: slice width and FSM state encoding.
package sum_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sum_seq_state_e;

endpackage

// File: rtl/SUM_cla4bit.sv
// Purpose: 4-bit carry-lookahead adder slice with group propagate/generate.
// Latency: purely combinational.
// Backpressure: none; the caller sequences it.
module SUM_cla4bit (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout,
    output logic       o_p,
    output logic       o_g
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    assign p = i_a ^ i_b;
    assign g = i_a & i_b;

    // Carries flattened from the generate/propagate terms, no ripple chain.
    assign c[0] = i_cin;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign o_sum  = p ^ c[3:0];
    assign o_cout = c[4];
    assign o_p    = &p;
    assign o_g    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/sum_seq_adder.sv
// Purpose: WIDTH-bit add/sub by time-multiplexing one 4-bit CLA slice LSB-first; SUM_SEQ_OVF_EN adds o_ovf.
// Latency: WIDTH/4 cycles from operand acceptance to o_valid; no overlap between operations.
// Backpressure: o_ready only in IDLE; result held in DONE until i_ready; i_flush aborts at any time.
module sum_seq_adder
    import sum_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    input  logic             i_sub,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
`ifdef SUM_SEQ_OVF_EN
    output logic             o_ovf,
`endif
    output logic             o_cout
);

    localparam int N  = WIDTH / NIBBLE_W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
        $fatal(1, "sum_seq_adder: WIDTH must be a multiple of 4 and at least 8");
    end

    sum_seq_state_e state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             carry_q;

    logic [NIBBLE_W-1:0] slice_sum;
    logic                slice_cout;
    logic                slice_p;
    logic                slice_g;
    logic                unused_slice_pg;
    logic [WIDTH-1:0]    res_next;

    SUM_cla4bit u_slice (
        .i_a    (a_q[NIBBLE_W-1:0]),
        .i_b    (b_q[NIBBLE_W-1:0]),
        .i_cin  (carry_q),
        .o_sum  (slice_sum),
        .o_cout (slice_cout),
        .o_p    (slice_p),
        .o_g    (slice_g)
    );

    assign unused_slice_pg = slice_p ^ slice_g;

    // Sum nibbles enter at the top so after N steps the LSB nibble sits at [3:0].
    assign res_next = {slice_sum, res_q[WIDTH-1:NIBBLE_W]};

    assign o_ready = (state_q == IDLE);
    assign o_valid = (state_q == DONE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            o_sum   <= '0;
            o_cout  <= 1'b0;
`ifdef SUM_SEQ_OVF_EN
            o_ovf   <= 1'b0;
`endif
        end else if (i_flush) begin
            state_q <= IDLE;
            o_sum   <= '0;
            o_cout  <= 1'b0;
`ifdef SUM_SEQ_OVF_EN
            o_ovf   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        a_q     <= i_a;
                        b_q     <= i_sub ? ~i_b : i_b;
                        carry_q <= i_sub | i_cin;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= {{NIBBLE_W{1'b0}}, a_q[WIDTH-1:NIBBLE_W]};
                    b_q     <= {{NIBBLE_W{1'b0}}, b_q[WIDTH-1:NIBBLE_W]};
                    res_q   <= res_next;
                    carry_q <= slice_cout;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        o_sum   <= res_next;
                        o_cout  <= slice_cout;
`ifdef SUM_SEQ_OVF_EN
                        // On the final step the slice sees the operand MSB nibbles.
                        o_ovf   <= (a_q[NIBBLE_W-1] == b_q[NIBBLE_W-1]) &
                                   (slice_sum[NIBBLE_W-1] != a_q[NIBBLE_W-1]);
`endif
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
